// File: rtl/pmem_arbiter.sv
// Arbiter sharing one line-wide physical memory port between icache fills and dcache fills/write-backs.
// Optional macro PMEM_ARB_ROUND_ROBIN_EN swaps fixed dcache priority for alternating tie-breaks.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds read/write high until it sees its one-cycle
  // *_resp, then drops it; any request still high while IDLE is a new transaction.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  state_e              state_q;
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [ADDR_W-1:0]   pmem_address_q;
  logic [LINE_W-1:0]   pmem_wdata_q;
  logic                d_req;
  logic                grant_d;

  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;
  // On a tie the side that did not own the previous grant wins.
  assign grant_d = d_req & (~i_pmem_read | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q        <= D_BUSY;
            // A simultaneous read+write is a write-back that must precede the fill.
            pmem_read_q    <= d_pmem_read & ~d_pmem_write;
            pmem_write_q   <= d_pmem_write;
            pmem_address_q <= d_pmem_address;
            pmem_wdata_q   <= d_pmem_wdata;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_d_q       <= 1'b1;
`endif
          end else if (i_pmem_read) begin
            state_q        <= I_BUSY;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= i_pmem_address;
            pmem_wdata_q   <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_d_q       <= 1'b0;
`endif
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Responses are forwarded in the memory's own resp cycle, only to the owner.
  assign i_pmem_resp  = (state_q == I_BUSY) & pmem_resp;
  assign d_pmem_resp  = (state_q == D_BUSY) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign dbg_state    = state_q;

endmodule
